// File: rtl/tinyalu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_pkg
// Purpose  : Opcode and FSM encodings shared by the TinyALU core and its bench.
//            Optional feature macro: TINYALU_SUB_EN (op 5 = subtract).
// Revision : 1.0 - initial release
// ============================================================================
package tinyalu_pkg;

  localparam int RESULT_W = 16;

  typedef enum logic [2:0] {
    NO_OP     = 3'd0,
    ADD_OP    = 3'd1,
    AND_OP    = 3'd2,
    XOR_OP    = 3'd3,
    MUL_OP    = 3'd4,
    SUB_OP    = 3'd5,
    UNUSED_OP = 3'd6,
    RST_OP    = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/tinyalu_if.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_if
// Purpose  : A/B/op/start -> done/result command bus between BFM and core.
// Revision : 1.0 - initial release
// ============================================================================
interface tinyalu_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   A;
  logic [DATA_W-1:0]   B;
  logic [2:0]          op;
  logic                start;
  logic                done;
  logic [2*DATA_W-1:0] result;

  modport master (output A, B, op, start, input done, result);
  modport slave  (input A, B, op, start, output done, result);
endinterface
`default_nettype wire

// File: rtl/tinyalu_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_mult_pipe
// Purpose  : Fixed-depth unsigned multiplier with a valid bit riding alongside.
// Revision : 1.0 - initial release
// ============================================================================
module tinyalu_mult_pipe #(
  parameter int DATA_W     = 8,
  parameter int MUL_STAGES = 3
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  input  wire logic                valid_in,
  input  wire logic [DATA_W-1:0]   a,
  input  wire logic [DATA_W-1:0]   b,
  output logic                     valid_out,
  output logic [2*DATA_W-1:0]      product
);

  localparam int c_prod_w = 2 * DATA_W;

  logic                r_valid [MUL_STAGES];
  logic [c_prod_w-1:0] r_prod  [MUL_STAGES];

  for (genvar i = 0; i < MUL_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid[0] <= 1'b0;
          r_prod[0]  <= '0;
        end else begin
          r_valid[0] <= valid_in;
          if (valid_in) begin
            r_prod[0] <= c_prod_w'(a) * c_prod_w'(b);
          end
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid[i] <= 1'b0;
          r_prod[i]  <= '0;
        end else begin
          r_valid[i] <= r_valid[i-1];
          r_prod[i]  <= r_prod[i-1];
        end
      end
    end
  end

  assign valid_out = r_valid[MUL_STAGES-1];
  assign product   = r_prod[MUL_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tinyalu_core.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_core
// Purpose  : TinyALU datapath: command FSM, single-cycle logic ops, pipelined
//            multiply, held result register. Macro TINYALU_SUB_EN enables op 5.
// Revision : 1.0 - initial release
// ============================================================================
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MUL_STAGES = 3
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  tinyalu_if.slave   bus
);

  localparam int c_res_w = 2 * DATA_W;

  alu_state_t          r_state;
  alu_state_t          w_state_next;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  operation_t          r_op;
  logic                r_done;
  logic [c_res_w-1:0]  r_result;

  logic                w_capture;
  logic                w_mul_start;
  logic                w_done_next;
  logic [c_res_w-1:0]  w_result_next;
  logic [c_res_w-1:0]  w_exec_result;
  logic                w_mul_valid;
  logic [c_res_w-1:0]  w_mul_product;

  // The pipe samples operands straight off the bus so the product lands
  // exactly MUL_STAGES edges after the capture edge.
  tinyalu_mult_pipe #(
    .DATA_W     (DATA_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mult_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_in  (w_mul_start),
    .a         (bus.A),
    .b         (bus.B),
    .valid_out (w_mul_valid),
    .product   (w_mul_product)
  );

  always_comb begin
    w_exec_result = '0;
    case (r_op)
      ADD_OP:  w_exec_result = c_res_w'(r_a) + c_res_w'(r_b);
      AND_OP:  w_exec_result = c_res_w'(r_a & r_b);
      XOR_OP:  w_exec_result = c_res_w'(r_a ^ r_b);
`ifdef TINYALU_SUB_EN
      SUB_OP:  w_exec_result = c_res_w'(r_a) - c_res_w'(r_b);
`endif
      default: w_exec_result = '0;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_done_next   = 1'b0;
    w_result_next = r_result;
    w_capture     = 1'b0;
    w_mul_start   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_capture = 1'b1;
          case (operation_t'(bus.op))
            ADD_OP, AND_OP, XOR_OP: w_state_next = EXEC;
`ifdef TINYALU_SUB_EN
            SUB_OP:                 w_state_next = EXEC;
`endif
            MUL_OP: begin
              w_mul_start  = 1'b1;
              w_state_next = MUL;
            end
            default:                w_state_next = IDLE;
          endcase
        end
      end
      EXEC: begin
        w_result_next = w_exec_result;
        w_done_next   = 1'b1;
        w_state_next  = DONE;
      end
      MUL: begin
        if (w_mul_valid) begin
          w_result_next = w_mul_product;
          w_done_next   = 1'b1;
          w_state_next  = DONE;
        end
      end
      // start is deliberately ignored here to force an idle cycle between commands
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= NO_OP;
    end else begin
      r_state  <= w_state_next;
      r_done   <= w_done_next;
      r_result <= w_result_next;
      if (w_capture) begin
        r_a  <= bus.A;
        r_b  <= bus.B;
        r_op <= operation_t'(bus.op);
      end
    end
  end

  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinyalu_core
// Purpose  : Directed self-checking bench for tinyalu_core (MUL_STAGES = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinyalu_core;
  import tinyalu_pkg::*;

  localparam int DATA_W     = 8;
  localparam int MUL_STAGES = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tinyalu_if #(.DATA_W(DATA_W)) bus ();

  tinyalu_core #(
    .DATA_W     (DATA_W),
    .MUL_STAGES (MUL_STAGES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, scramble the bus after capture, return edges to done (0 = timeout).
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input bit hold, output int lat);
    bus.A = a; bus.B = b; bus.op = o; bus.start = 1'b1;
    tick();
    check_eq("no_done_on_capture", 32'(bus.done), 32'd0);
    bus.A = ~a; bus.B = ~b; bus.op = 3'd6;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (!hold) bus.start = 1'b0;
  endtask

  int lat;
  bit seen;

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_result", 32'(bus.result), 32'd0);

    do_op(ADD_OP, 8'd255, 8'd255, 1'b0, lat);
    check_eq("add_latency", lat, 1);
    check_eq("add_result", 32'(bus.result), 32'h01FE);
    tick();
    check_eq("add_done_one_cycle", 32'(bus.done), 32'd0);

    do_op(MUL_OP, 8'd200, 8'd150, 1'b0, lat);
    check_eq("mul_latency", lat, MUL_STAGES);
    check_eq("mul_result", 32'(bus.result), 32'h7530);
    tick();
    check_eq("mul_done_one_cycle", 32'(bus.done), 32'd0);

    do_op(XOR_OP, 8'hF0, 8'h3C, 1'b0, lat);
    check_eq("xor_latency", lat, 1);
    check_eq("xor_result", 32'(bus.result), 32'h00CC);
    tick();

    bus.A = 8'd1; bus.B = 8'd1; bus.op = NO_OP; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= bus.done; end
    check_eq("noop_no_done", 32'(seen), 32'd0);
    check_eq("noop_result_held", 32'(bus.result), 32'h00CC);

    // Reset lands one edge into a multiply
    bus.A = 8'd10; bus.B = 8'd10; bus.op = MUL_OP; bus.start = 1'b1;
    tick();
    reset_n = 1'b0;
    bus.start = 1'b0;
    #1;
    check_eq("async_rst_result", 32'(bus.result), 32'd0);
    check_eq("async_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= bus.done; end
    check_eq("rst_mul_no_done", 32'(seen), 32'd0);
    check_eq("rst_mul_result", 32'(bus.result), 32'd0);

    do_op(ADD_OP, 8'd1, 8'd2, 1'b0, lat);
    check_eq("post_rst_add_latency", lat, 1);
    check_eq("post_rst_add_result", 32'(bus.result), 32'd3);
    tick();

`ifdef TINYALU_SUB_EN
    do_op(SUB_OP, 8'd3, 8'd5, 1'b0, lat);
    check_eq("sub_latency", lat, 1);
    check_eq("sub_result", 32'(bus.result), 32'hFFFE);
    tick();
    check_eq("sub_done_one_cycle", 32'(bus.done), 32'd0);
`else
    bus.A = 8'd3; bus.B = 8'd5; bus.op = SUB_OP; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= bus.done; end
    check_eq("sub_off_no_done", 32'(seen), 32'd0);
    check_eq("sub_off_result_held", 32'(bus.result), 32'd3);
`endif

    // start stays high through DONE with a new command already on the bus
    do_op(AND_OP, 8'h0F, 8'h3C, 1'b1, lat);
    check_eq("and_latency", lat, 1);
    check_eq("and_result", 32'(bus.result), 32'h000C);
    bus.A = 8'd7; bus.B = 8'd8; bus.op = ADD_OP;
    tick();
    check_eq("held_done_edge_done", 32'(bus.done), 32'd0);
    check_eq("held_done_edge_result", 32'(bus.result), 32'h000C);
    tick();
    check_eq("held_capture_edge_done", 32'(bus.done), 32'd0);
    tick();
    check_eq("held_add_done", 32'(bus.done), 32'd1);
    check_eq("held_add_result", 32'(bus.result), 32'h000F);
    bus.start = 1'b0;
    tick();
    check_eq("held_add_done_drop", 32'(bus.done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
